// File: rtl/glb_burst_feeder.sv
// Multi-channel GLB burst reader: per-channel strided burst FSM + 2-deep output FIFO,
// sharing one GLB read port through a round-robin arbiter.

module glb_feeder_ch #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic [ADDR_WIDTH-1:0] stride,
  input  logic                  grant,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  ready,
  output logic                  req,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  done
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, stride_q;
  logic [LEN_WIDTH-1:0]  rem_q;
  logic [DATA_WIDTH-1:0] fifo_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            cnt_q;
  logic                  done_q;
  logic                  pop;
  logic [2:0]            occ;

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = fifo_q[rd_ptr_q];
  assign pop       = out_valid & ready;
  assign addr      = addr_q;
  assign done      = done_q;
  // push is the read granted last cycle, so it doubles as the in-flight flag
  assign occ       = {1'b0, cnt_q} + {2'b0, push} - {2'b0, pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && length != '0)         state_d = RUN;
      RUN:     if (grant && rem_q == LEN_WIDTH'(1)) state_d = DRAIN;
      DRAIN:   if (cnt_q == 2'd0 && !push)        state_d = IDLE;
      default:                                    state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    req  = (state_q == RUN) && (rem_q != '0) && (occ < 3'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      stride_q <= '0;
      rem_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state_q == IDLE && start && length == '0) ||
                (state_q == DRAIN && state_d == IDLE);
      if (state_q == IDLE && start && length != '0) begin
        addr_q   <= start_addr;
        stride_q <= stride;
        rem_q    <= length;
      end else if (grant) begin
        addr_q <= addr_q + stride_q;
        rem_q  <= rem_q - LEN_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= push_data;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

module glb_burst_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 8,
  parameter int NUM_CH     = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_CH-1:0]                    start,
  input  logic [NUM_CH-1:0][ADDR_WIDTH-1:0]    start_addr,
  input  logic [NUM_CH-1:0][LEN_WIDTH-1:0]     length,
  input  logic [NUM_CH-1:0][ADDR_WIDTH-1:0]    stride,
  output logic                                 mem_rd_en,
  output logic [ADDR_WIDTH-1:0]                mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]                mem_rd_data,
  output logic [NUM_CH-1:0][DATA_WIDTH-1:0]    out_data,
  output logic [NUM_CH-1:0]                    out_valid,
  input  logic [NUM_CH-1:0]                    out_ready,
  output logic [NUM_CH-1:0]                    busy,
  output logic [NUM_CH-1:0]                    done
);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]                 req, gnt, push;
  logic [NUM_CH-1:0][ADDR_WIDTH-1:0] ch_addr;
  logic [CW-1:0]                     ptr_q, gnt_idx, idx;
  logic                              gnt_any;
  logic                              rd_vld_q;
  logic [CW-1:0]                     rd_ch_q;

  // Round-robin: scan from ptr_q, first requester wins
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = CW'((int'(ptr_q) + k) % NUM_CH);
      if (!gnt_any && req[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  assign gnt         = gnt_any ? (NUM_CH'(1) << gnt_idx) : '0;
  assign mem_rd_en   = gnt_any;
  assign mem_rd_addr = gnt_any ? ch_addr[gnt_idx] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      rd_vld_q <= 1'b0;
      rd_ch_q  <= '0;
    end else begin
      rd_vld_q <= gnt_any;
      rd_ch_q  <= gnt_idx;
      if (gnt_any) ptr_q <= (gnt_idx == CW'(NUM_CH - 1)) ? '0 : gnt_idx + CW'(1);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign push[i] = rd_vld_q && (rd_ch_q == CW'(i));

    glb_feeder_ch #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .LEN_WIDTH  (LEN_WIDTH)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start[i]),
      .start_addr (start_addr[i]),
      .length     (length[i]),
      .stride     (stride[i]),
      .grant      (gnt[i]),
      .push       (push[i]),
      .push_data  (mem_rd_data),
      .ready      (out_ready[i]),
      .req        (req[i]),
      .addr       (ch_addr[i]),
      .out_data   (out_data[i]),
      .out_valid  (out_valid[i]),
      .busy       (busy[i]),
      .done       (done[i])
    );
  end
endmodule
